missile_object: RTL

Drawing-side producer for one missile: owns missile state and position, and answers each scanned pixel with a registered drawing request and colour. Outputs feed the missile request/RGB input pair of the object priority mux. Two instances run in the design, one per tank. The block launches on a fire pulse, moves once per frame, and terminates on collision or screen exit.

---
 rtl/battle_pkg.sv | 32 +++
 rtl/box_hit.sv | 22 ++
 rtl/missile_object.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/battle_pkg.sv
// Shared types and constants for the battle game objects (tanks, missiles).
package battle_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } direction_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_FLYING = 2'd2
    } missile_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [7:0] TRANSPARENT = 8'h00;

    // True when a signed top-left corner lies inside [0, max_x] x [0, max_y].
    function automatic logic in_bounds(
        input logic signed [11:0] x,
        input logic signed [11:0] y,
        input logic signed [11:0] max_x,
        input logic signed [11:0] max_y
    );
        return (x >= 12'sd0) && (x <= max_x) && (y >= 12'sd0) && (y <= max_y);
    endfunction

endpackage

// File: rtl/box_hit.sv
// Combinational square/rectangle containment test, shared by tank and missile objects.
module box_hit (
    input  logic [11:0] point_x_i,
    input  logic [11:0] point_y_i,
    input  logic [11:0] tl_x_i,
    input  logic [11:0] tl_y_i,
    input  logic [11:0] size_i,
    output logic        inside_o
);

    logic [12:0] end_x_s;
    logic [12:0] end_y_s;

    // Right/bottom edges are computed one bit wider so they never wrap.
    always_comb begin
        end_x_s  = {1'b0, tl_x_i} + {1'b0, size_i};
        end_y_s  = {1'b0, tl_y_i} + {1'b0, size_i};
        inside_o = (point_x_i >= tl_x_i) && ({1'b0, point_x_i} < end_x_s) &&
                   (point_y_i >= tl_y_i) && ({1'b0, point_y_i} < end_y_s);
    end

endmodule

// File: rtl/missile_object.sv
// One missile: launch from the owning tank, per-frame motion, termination on
// collision or screen exit, and a registered pixel draw request with colour.
module missile_object
    import battle_pkg::*;
#(
    parameter int         SIZE      = 4,
    parameter int         SPEED     = 4,
    parameter int         TANK_SIZE = 32,
    parameter logic [7:0] COLOR     = 8'hFC,
    parameter int         SCR_W     = SCREEN_W,
    parameter int         SCR_H     = SCREEN_H
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        fire,
    input  logic [10:0] tankTopLeftX,
    input  logic [10:0] tankTopLeftY,
    input  logic [1:0]  tankDirection,
    input  logic        collision,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        drawingRequest,
    output logic [7:0]  RGB,
    output logic        active
);

    localparam logic signed [11:0] SIZE_S     = 12'(SIZE);
    localparam logic signed [11:0] SPEED_S    = 12'(SPEED);
    localparam logic signed [11:0] TANK_S     = 12'(TANK_SIZE);
    localparam logic signed [11:0] CENTER_OFF = 12'(TANK_SIZE / 2 - SIZE / 2);
    localparam logic signed [11:0] MAX_X      = 12'(SCR_W - SIZE);
    localparam logic signed [11:0] MAX_Y      = 12'(SCR_H - SIZE);

    missile_state_t    state_q, state_d;
    direction_t        dir_q, dir_d;
    logic signed [11:0] tank_x_q, tank_x_d;
    logic signed [11:0] tank_y_q, tank_y_d;
    logic signed [11:0] pos_x_q, pos_x_d;
    logic signed [11:0] pos_y_q, pos_y_d;
    logic              draw_q, draw_d;
    logic [7:0]        rgb_q, rgb_d;

    logic signed [11:0] center_x_s, center_y_s;
    logic signed [11:0] spawn_x_s, spawn_y_s;
    logic signed [11:0] move_x_s, move_y_s;
    logic              hit_s;

    box_hit u_box_hit (
        .point_x_i ({1'b0, pixelX}),
        .point_y_i ({1'b0, pixelY}),
        .tl_x_i    (pos_x_q),
        .tl_y_i    (pos_y_q),
        .size_i    (SIZE_S),
        .inside_o  (hit_s)
    );

    // Spawn point next to the tank and the candidate one-frame step, by direction.
    always_comb begin
        center_x_s = tank_x_q + CENTER_OFF;
        center_y_s = tank_y_q + CENTER_OFF;
        spawn_x_s  = center_x_s;
        spawn_y_s  = center_y_s;
        move_x_s   = pos_x_q;
        move_y_s   = pos_y_q;
        case (dir_q)
            DIR_UP: begin
                spawn_x_s = center_x_s;
                spawn_y_s = tank_y_q - SIZE_S;
                move_y_s  = pos_y_q - SPEED_S;
            end
            DIR_RIGHT: begin
                spawn_x_s = tank_x_q + TANK_S;
                spawn_y_s = center_y_s;
                move_x_s  = pos_x_q + SPEED_S;
            end
            DIR_DOWN: begin
                spawn_x_s = center_x_s;
                spawn_y_s = tank_y_q + TANK_S;
                move_y_s  = pos_y_q + SPEED_S;
            end
            DIR_LEFT: begin
                spawn_x_s = tank_x_q - SIZE_S;
                spawn_y_s = center_y_s;
                move_x_s  = pos_x_q - SPEED_S;
            end
            default: begin
                spawn_x_s = center_x_s;
                spawn_y_s = center_y_s;
            end
        endcase
    end

    // Next-state logic; collision outranks frame motion while flying.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        tank_x_d = tank_x_q;
        tank_y_d = tank_y_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    tank_x_d = $signed({1'b0, tankTopLeftX});
                    tank_y_d = $signed({1'b0, tankTopLeftY});
                    dir_d    = direction_t'(tankDirection);
                    state_d  = ST_LAUNCH;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (in_bounds(spawn_x_s, spawn_y_s, MAX_X, MAX_Y)) begin
                    pos_x_d = spawn_x_s;
                    pos_y_d = spawn_y_s;
                    state_d = ST_FLYING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLYING: begin
                if (collision) begin
                    state_d = ST_IDLE;
                end else if (startOfFrame) begin
                    if (in_bounds(move_x_s, move_y_s, MAX_X, MAX_Y)) begin
                        pos_x_d = move_x_s;
                        pos_y_d = move_y_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_FLYING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pixel answer, registered one clock behind pixelX/pixelY.
    always_comb begin
        draw_d = (state_q == ST_FLYING) && hit_s;
        if (draw_d) begin
            rgb_d = COLOR;
        end else begin
            rgb_d = TRANSPARENT;
        end
    end

    // State, captured launch parameters, position and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_UP;
            tank_x_q <= 12'sd0;
            tank_y_q <= 12'sd0;
            pos_x_q  <= 12'sd0;
            pos_y_q  <= 12'sd0;
            draw_q   <= 1'b0;
            rgb_q    <= TRANSPARENT;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            tank_x_q <= tank_x_d;
            tank_y_q <= tank_y_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            draw_q   <= draw_d;
            rgb_q    <= rgb_d;
        end
    end

    assign drawingRequest = draw_q;
    assign RGB            = rgb_q;
    assign active         = (state_q != ST_IDLE);

endmodule
